change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser.sv | 186 ++++++++++++++++++
 tb/tb_change_dispenser.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Coin change dispenser: greedy 100/50/25 payout with per-coin eject pulse and sensor handshake.
// Define CHANGE_DISPENSER_INVENTORY_EN to enable stock tracking and loading.
module change_dispenser #(
    parameter int unsigned PULSE_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        dar_troco,
    input  logic [7:0]  valor_troco,
    input  logic        moeda_detectada,
    input  logic        carregar,
    input  logic [11:0] moedas_inseridas,
    output logic        ejeta_100,
    output logic        ejeta_050,
    output logic        ejeta_025,
    output logic [7:0]  troco_restante,
    output logic [11:0] moedas_carteira,
    output logic        ocupado,
    output logic        concluido,
    output logic        erro
);

    localparam int unsigned CntMax = (PULSE_CYCLES > TIMEOUT_CYCLES) ? PULSE_CYCLES
                                                                      : TIMEOUT_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] PulseLast   = CntW'(PULSE_CYCLES - 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StPulse,
        StWait,
        StDone,
        StErro
    } state_t;

    typedef enum logic [1:0] {
        CoinNone,
        Coin100,
        Coin050,
        Coin025
    } coin_t;

    state_t          state_q, state_d;
    coin_t           coin_q, coin_d, coin_pick;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      troco_q, troco_d;
    logic            has_100, has_050, has_025;
    logic            load_req;

    function automatic logic [7:0] coin_value(input coin_t c);
        unique case (c)
            Coin100:  return 8'd100;
            Coin050:  return 8'd50;
            Coin025:  return 8'd25;
            default:  return 8'd0;
        endcase
    endfunction

`ifdef CHANGE_DISPENSER_INVENTORY_EN
    logic [11:0] stock_q, stock_d;

    assign has_100         = (stock_q[11:8] != 4'd0);
    assign has_050         = (stock_q[7:4]  != 4'd0);
    assign has_025         = (stock_q[3:0]  != 4'd0);
    assign load_req        = carregar;
    assign moedas_carteira = stock_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stock_q <= '0;
        end else begin
            stock_q <= stock_d;
        end
    end

    always_comb begin
        stock_d = stock_q;
        if (state_q == StIdle && load_req) begin
            stock_d = moedas_inseridas;
        end else if (state_q == StWait && moeda_detectada) begin
            unique case (coin_q)
                Coin100: stock_d[11:8] = stock_q[11:8] - 4'd1;
                Coin050: stock_d[7:4]  = stock_q[7:4]  - 4'd1;
                Coin025: stock_d[3:0]  = stock_q[3:0]  - 4'd1;
                default: stock_d = stock_q;
            endcase
        end
    end
`else
    // Unlimited stock: the load port exists only for interface compatibility.
    logic unused_load;

    assign unused_load     = ^{carregar, moedas_inseridas};
    assign has_100         = 1'b1;
    assign has_050         = 1'b1;
    assign has_025         = 1'b1;
    assign load_req        = 1'b0;
    assign moedas_carteira = '0;
`endif

    // Greedy pick; the value test guarantees the later subtraction cannot underflow.
    always_comb begin
        coin_pick = CoinNone;
        if (troco_q >= 8'd100 && has_100) begin
            coin_pick = Coin100;
        end else if (troco_q >= 8'd50 && has_050) begin
            coin_pick = Coin050;
        end else if (troco_q >= 8'd25 && has_025) begin
            coin_pick = Coin025;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            coin_q  <= CoinNone;
            cnt_q   <= '0;
            troco_q <= '0;
        end else begin
            state_q <= state_d;
            coin_q  <= coin_d;
            cnt_q   <= cnt_d;
            troco_q <= troco_d;
        end
    end

    always_comb begin
        state_d = state_q;
        coin_d  = coin_q;
        cnt_d   = cnt_q;
        troco_d = troco_q;
        unique case (state_q)
            StIdle: begin
                // A load in the same cycle wins over a start request.
                if (!load_req && dar_troco) begin
                    troco_d = valor_troco;
                    state_d = StSelect;
                end
            end
            StSelect: begin
                if (troco_q == 8'd0) begin
                    state_d = StDone;
                end else if (coin_pick == CoinNone) begin
                    state_d = StErro;
                end else begin
                    coin_d  = coin_pick;
                    cnt_d   = '0;
                    state_d = StPulse;
                end
            end
            StPulse: begin
                if (cnt_q == PulseLast) begin
                    cnt_d   = '0;
                    state_d = StWait;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWait: begin
                if (moeda_detectada) begin
                    troco_d = troco_q - coin_value(coin_q);
                    state_d = StSelect;
                end else if (cnt_q == TimeoutLast) begin
                    state_d = StErro;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone:  state_d = StIdle;
            StErro:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign ejeta_100      = (state_q == StPulse) && (coin_q == Coin100);
    assign ejeta_050      = (state_q == StPulse) && (coin_q == Coin050);
    assign ejeta_025      = (state_q == StPulse) && (coin_q == Coin025);
    assign troco_restante = troco_q;
    assign ocupado        = (state_q != StIdle);
    assign concluido      = (state_q == StDone);
    assign erro           = (state_q == StErro);

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser; expectations follow the
// CHANGE_DISPENSER_INVENTORY_EN setting of the build.
module tb_change_dispenser;

    localparam int unsigned PulseCyc   = 4;
    localparam int unsigned TimeoutCyc = 255;
`ifdef CHANGE_DISPENSER_INVENTORY_EN
    localparam bit Inv = 1'b1;
`else
    localparam bit Inv = 1'b0;
`endif

    logic        clock;
    logic        reset_n;
    logic        dar_troco;
    logic [7:0]  valor_troco;
    logic        moeda_detectada;
    logic        carregar;
    logic [11:0] moedas_inseridas;
    logic        ejeta_100;
    logic        ejeta_050;
    logic        ejeta_025;
    logic [7:0]  troco_restante;
    logic [11:0] moedas_carteira;
    logic        ocupado;
    logic        concluido;
    logic        erro;

    change_dispenser #(
        .PULSE_CYCLES   (PulseCyc),
        .TIMEOUT_CYCLES (TimeoutCyc)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .dar_troco        (dar_troco),
        .valor_troco      (valor_troco),
        .moeda_detectada  (moeda_detectada),
        .carregar         (carregar),
        .moedas_inseridas (moedas_inseridas),
        .ejeta_100        (ejeta_100),
        .ejeta_050        (ejeta_050),
        .ejeta_025        (ejeta_025),
        .troco_restante   (troco_restante),
        .moedas_carteira  (moedas_carteira),
        .ocupado          (ocupado),
        .concluido        (concluido),
        .erro             (erro)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_total = 0;
    int n_bad   = 0;

    // Transaction record filled by run_pay
    logic [31:0] r_seq;
    int          r_n, r_bad_w, r_multi, r_end, r_wait_at;
    bit          r_done, r_err, r_busy1;
    logic [7:0]  r_troco;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [11:0] v);
        carregar         = 1'b1;
        moedas_inseridas = v;
        step();
        carregar         = 1'b0;
    endtask

    // Starts a payout and logs eject codes (1=100, 2=50, 3=25) until concluido/erro.
    // poke injects ignored load/start/sensor activity during the first pulse.
    task automatic run_pay(input logic [7:0] valor, input bit ack, input bit poke);
        int prev;
        int cur;
        int w;
        bit fin;
        dar_troco   = 1'b1;
        valor_troco = valor;
        step();
        dar_troco = 1'b0;
        r_seq = '0; r_n = 0; r_bad_w = 0; r_multi = 0; r_end = 0; r_wait_at = 0;
        r_done = 1'b0; r_err = 1'b0; r_busy1 = 1'b0; r_troco = '0;
        prev = 0; w = 0; fin = 1'b0;
        for (int c = 1; c <= 2000 && !fin; c++) begin
            moeda_detectada = 1'b0;
            carregar        = 1'b0;
            dar_troco       = 1'b0;
            if (c == 1) r_busy1 = ocupado;
            if (int'(ejeta_100) + int'(ejeta_050) + int'(ejeta_025) > 1) r_multi++;
            cur = ejeta_100 ? 1 : ejeta_050 ? 2 : ejeta_025 ? 3 : 0;
            if (cur != 0 && cur == prev) begin
                w++;
            end else if (cur != 0) begin
                r_seq = (r_seq << 4) | 32'(cur);
                r_n++;
                w = 1;
            end
            if (cur == 0 && prev != 0) begin
                if (w != int'(PulseCyc)) r_bad_w++;
                r_wait_at = c;
                if (ack) moeda_detectada = 1'b1;
            end
            if (poke && c == 2) begin
                carregar         = 1'b1;
                moedas_inseridas = 12'h777;
                dar_troco        = 1'b1;
                valor_troco      = 8'd200;
            end
            if (poke && c == 3) moeda_detectada = 1'b1;
            if (concluido || erro) begin
                fin     = 1'b1;
                r_done  = concluido;
                r_err   = erro;
                r_troco = troco_restante;
                r_end   = c;
            end
            prev = cur;
            if (!fin) step();
        end
        check_eq("pay_finished", 32'(fin), 32'd1);
        moeda_detectada = 1'b0;
        carregar        = 1'b0;
        dar_troco       = 1'b0;
        step();
        check_eq("idle_after_pay", 32'(ocupado), 32'd0);
    endtask

    initial begin
        bit act;
        reset_n          = 1'b0;
        dar_troco        = 1'b0;
        valor_troco      = '0;
        moeda_detectada  = 1'b0;
        carregar         = 1'b0;
        moedas_inseridas = '0;
        repeat (2) step();

        check_eq("rst_ejeta", {29'd0, ejeta_100, ejeta_050, ejeta_025}, 32'd0);
        check_eq("rst_flags", {29'd0, ocupado, concluido, erro}, 32'd0);
        check_eq("rst_troco", 32'(troco_restante), 32'd0);
        check_eq("rst_carteira", 32'(moedas_carteira), 32'd0);
        #2 reset_n = 1'b1;
        act = 1'b0;
        repeat (3) begin
            step();
            act |= ocupado | ejeta_100 | ejeta_050 | ejeta_025 | concluido | erro;
        end
        check_eq("quiet_after_release", 32'(act), 32'd0);

        // 75 with full stock: 50 then 25
        load(12'hFFF);
        check_eq("load_fff", 32'(moedas_carteira), Inv ? 32'hFFF : 32'h0);
        run_pay(8'd75, 1'b1, 1'b0);
        check_eq("p75_busy", 32'(r_busy1), 32'd1);
        check_eq("p75_seq", r_seq, 32'h23);
        check_eq("p75_width", 32'(r_bad_w), 32'd0);
        check_eq("p75_onehot", 32'(r_multi), 32'd0);
        check_eq("p75_done", {30'd0, r_done, r_err}, 32'b10);
        check_eq("p75_troco", 32'(r_troco), 32'd0);
        check_eq("p75_carteira", 32'(moedas_carteira), Inv ? 32'hFEE : 32'h0);

        // Zero amount completes with no eject
        run_pay(8'd0, 1'b1, 1'b0);
        check_eq("p0_count", 32'(r_n), 32'd0);
        check_eq("p0_done", {30'd0, r_done, r_err}, 32'b10);
        check_eq("p0_latency", 32'(r_end), 32'd2);

        // 130: remainder 5 ends in erro
        load(12'hFFF);
        run_pay(8'd130, 1'b1, 1'b0);
        check_eq("p130_seq", r_seq, 32'h13);
        check_eq("p130_err", {30'd0, r_done, r_err}, 32'b01);
        check_eq("p130_troco", 32'(r_troco), 32'd5);

        // Limited stock 12'h011, amount 100
        load(12'h011);
        run_pay(8'd100, 1'b1, 1'b0);
        check_eq("p100s_seq", r_seq, Inv ? 32'h23 : 32'h1);
        check_eq("p100s_end", {30'd0, r_done, r_err}, Inv ? 32'b01 : 32'b10);
        check_eq("p100s_troco", 32'(r_troco), Inv ? 32'd25 : 32'd0);
        check_eq("p100s_carteira", 32'(moedas_carteira), 32'd0);

        // Sensor never fires: timeout from WAIT entry
        load(12'hFFF);
        run_pay(8'd50, 1'b0, 1'b0);
        check_eq("tmo_seq", r_seq, 32'h2);
        check_eq("tmo_err", {30'd0, r_done, r_err}, 32'b01);
        check_eq("tmo_troco", 32'(r_troco), 32'd50);
        check_eq("tmo_latency", 32'(r_end - r_wait_at), 32'(TimeoutCyc));
        check_eq("tmo_carteira", 32'(moedas_carteira), Inv ? 32'hFFF : 32'h0);

        // Load and start together: load wins when inventory exists
        carregar         = 1'b1;
        moedas_inseridas = 12'h123;
        dar_troco        = 1'b1;
        valor_troco      = 8'd0;
        step();
        carregar  = 1'b0;
        dar_troco = 1'b0;
        check_eq("both_busy", 32'(ocupado), Inv ? 32'd0 : 32'd1);
        check_eq("both_carteira", 32'(moedas_carteira), Inv ? 32'h123 : 32'h0);
        repeat (4) step();
        check_eq("both_settled", 32'(ocupado), 32'd0);

        // Load, start and sensor while busy are ignored
        run_pay(8'd25, 1'b1, 1'b1);
        check_eq("poke_seq", r_seq, 32'h3);
        check_eq("poke_done", {30'd0, r_done, r_err}, 32'b10);
        check_eq("poke_troco", 32'(r_troco), 32'd0);
        check_eq("poke_carteira", 32'(moedas_carteira), Inv ? 32'h122 : 32'h0);

        // Reset in the third cycle of an ejeta_100 pulse
        load(12'hFFF);
        dar_troco   = 1'b1;
        valor_troco = 8'd100;
        step();
        dar_troco = 1'b0;
        repeat (3) step();
        check_eq("pre_reset_pulse", 32'(ejeta_100), 32'd1);
        #2;
        reset_n     = 1'b0;
        dar_troco   = 1'b1;
        valor_troco = 8'd25;
        #1;
        check_eq("mid_rst_ejeta", {29'd0, ejeta_100, ejeta_050, ejeta_025}, 32'd0);
        check_eq("mid_rst_flags", {29'd0, ocupado, concluido, erro}, 32'd0);
        check_eq("mid_rst_troco", 32'(troco_restante), 32'd0);
        check_eq("mid_rst_carteira", 32'(moedas_carteira), 32'd0);
        repeat (2) step();
        check_eq("rst_start_ignored", 32'(ocupado), 32'd0);
        dar_troco = 1'b0;
        #2 reset_n = 1'b1;
        act = 1'b0;
        repeat (6) begin
            step();
            act |= ocupado | ejeta_100 | ejeta_050 | ejeta_025 | concluido | erro;
        end
        check_eq("quiet_after_mid_rst", 32'(act), 32'd0);
        run_pay(8'd25, 1'b1, 1'b0);
        check_eq("post_rst_end", {30'd0, r_done, r_err}, Inv ? 32'b01 : 32'b10);
        check_eq("post_rst_troco", 32'(r_troco), Inv ? 32'd25 : 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
